dlx_pipe_ctrl: RTL and testbench
================================

// Module: dlx_pipe_ctrl
// PURPOSE
//  Pipelined DLX control unit: decodes ID-stage opcode/funct into a control bundle and carries it
//  through ID/EX, EX/MEM, MEM/WB registers. Detects load-use hazards (stall + bubble) and sequences
//  multi-cycle flushes on taken branch/jump/JR redirects. Sits between the IF/ID register and datapath muxes.
// PARAMETERS
//  ALUOP_W    6  ALU opcode width (funct passthrough for R/Mult types)
//  REG_AW     5  register-index width
//  FLUSH_CYC  1  cycles if/id/ex_flush stay high after a redirect (1..7)
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        asynchronous, active-high reset
//  id_valid      in   1        IF/ID holds a real instruction
//  id_opcode     in   6        instruction[31:26]
//  id_funct      in   6        instruction[5:0]
//  id_rs1        in   REG_AW   source reg 1
//  id_rs2        in   REG_AW   source reg 2 (dest for I-type)
//  id_rd         in   REG_AW   R-type dest
//  ex_redirect   in   1        branch/jump/JR resolved taken in EX (1-cycle pulse)
//  pc_stall      out  1        hold PC
//  ifid_stall    out  1        hold IF/ID
//  if_flush      out  1        squash IF/ID
//  id_flush      out  1        squash ID/EX bundle
//  ex_flush      out  1        squash EX/MEM bundle
//  ex_alu_op     out  ALUOP_W  ID/EX ALU op
//  ex_alu_src    out  1        1 = immediate operand
//  ex_branch     out  1        BEQ/BNEZ in EX
//  ex_jump       out  1        J in EX
//  ex_jr         out  1        JR in EX
//  mem_read      out  1        EX/MEM load
//  mem_write     out  1        EX/MEM store
//  wb_reg_write  out  1        MEM/WB register write
//  wb_mem_to_reg out  1        1 = ALU result, 0 = memory data (datapath encoding)
//  wb_rd         out  REG_AW   MEM/WB destination
//  illegal       out  1        registered: ID held an undecodable opcode last cycle
// BEHAVIOUR
//  - Decode: ADDI..SGEI -> alu_src=1, reg_write=1, dest=rs2, ALU ops 20..2d/04/06/07; R(00)/Mult(01) ->
//    alu_op=funct, dest=id_rd; LW: mem_read, op 20; SW: mem_write, op 20; J: jump; JR(12): jr; BEQ/BNEZ: branch, op 22.
//  - Unknown opcode or id_valid=0: all-zero bundle (never X); illegal=1 next cycle only if id_valid.
//  - Writes to r0 suppress reg_write. Bundle advances every cycle; latency ID->WB = 3 clocks.
//  - Load-use: ID/EX.mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2) -> pc_stall=ifid_stall=1
//    combinationally, zero bundle into ID/EX next edge; exactly one stall cycle per hazard.
//  - FSM RUN/FLUSH: ex_redirect in RUN -> flush outputs high that cycle, FLUSH, cnt=FLUSH_CYC-1;
//    FLUSH decrements to 0 then RUN. Flush zeroes bundles entering ID/EX and EX/MEM.
//  - redirect during FLUSH reloads cnt; redirect + load-use same cycle: redirect wins, stall deasserted.
//  - Reset (any time): state RUN, cnt 0, all pipeline bundles zero, every output 0.
// CONFIGURATION
//  DLX_CTRL_LINK_EN defined: decode JAL(03)/JALR(13) as jump/jr with reg_write=1, dest=31, alu_op=11
//  (PC+8 path). Undefined: 03/13 are illegal opcodes (zero bundle, illegal=1).
// STRUCTURE
//  Shared package dlx_ctrl_pkg: opcode constants, ALU op codes, ctrl_bundle_t struct, zero bundle.
//  One sub-module dlx_ctrl_decode (pure combinational opcode/funct -> bundle); pipeline regs,
//  hazard logic and flush FSM stay in this module.
// TESTING
//  ADDI r2,r1,5 then idle -> ex_alu_op=20/alu_src=1 at +1; wb_reg_write=1, wb_rd=2, wb_mem_to_reg=1 at +3.
//  LW r3 then ADD r4,r3,r1 -> pc_stall=ifid_stall=1 one cycle, bubble in EX, ADD issues next cycle.
//  LW r0 then ADD r4,r0,r0 -> no stall.
//  FLUSH_CYC=3, ex_redirect pulse -> if/id/ex_flush high exactly 3 cycles; redirect mid-flush extends to 3 more.
//  Opcode 3f with id_valid=1 -> zero bundle, illegal=1 one cycle; 03 illegal only without DLX_CTRL_LINK_EN.
//  rst asserted mid-stall/flush -> all outputs 0 asynchronously, RUN on release.

Source files
------------

// File: rtl/dlx_ctrl_pkg.sv
// Shared definitions for the DLX pipeline control slice.
//   - DLX primary opcode constants (instruction[31:26])
//   - ALU operation codes (R-type funct encoding, reused for immediates)
//   - ctrl_bundle_t: the control word carried from ID into the ID/EX register
//   - imm_alu_op(): maps an immediate-ALU opcode onto its R-type funct code
package dlx_ctrl_pkg;

  localparam int CTRL_ALUOP_W = 6;
  localparam int CTRL_REG_AW  = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_MULT  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDUI = 6'h09;
  localparam logic [5:0] OP_SUBI  = 6'h0a;
  localparam logic [5:0] OP_SUBUI = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LHI   = 6'h0f;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] OP_SLLI  = 6'h14;
  localparam logic [5:0] OP_SRLI  = 6'h16;
  localparam logic [5:0] OP_SRAI  = 6'h17;
  localparam logic [5:0] OP_SEQI  = 6'h18;
  localparam logic [5:0] OP_SNEI  = 6'h19;
  localparam logic [5:0] OP_SLTI  = 6'h1a;
  localparam logic [5:0] OP_SGTI  = 6'h1b;
  localparam logic [5:0] OP_SLEI  = 6'h1c;
  localparam logic [5:0] OP_SGEI  = 6'h1d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [CTRL_ALUOP_W-1:0] ALU_NONE = 6'h00;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_LINK = 6'h11;  // PC+8 onto the result bus
  localparam logic [CTRL_ALUOP_W-1:0] ALU_ADD  = 6'h20;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SUB  = 6'h22;

  localparam logic [CTRL_REG_AW-1:0] LINK_REG = 5'd31;

  typedef struct packed {
    logic [CTRL_ALUOP_W-1:0] alu_op;
    logic                    alu_src;
    logic                    branch;
    logic                    jump;
    logic                    jr;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_write;
    logic                    mem_to_reg;  // 1 = ALU result, 0 = memory data
    logic [CTRL_REG_AW-1:0]  rd;          // 0 whenever reg_write is 0
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_ZERO = '0;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} flush_state_t;

  // Immediate opcodes sit in three octets whose low three bits line up
  // with the low bits of the matching R-type funct code.
  function automatic logic [CTRL_ALUOP_W-1:0] imm_alu_op(input logic [5:0] opcode);
    logic [CTRL_ALUOP_W-1:0] op;
    case (opcode[5:3])
      3'b001:  op = {3'b100, opcode[2:0]};  // 08..0f -> 20..27
      3'b010:  op = {3'b000, opcode[2:0]};  // 14/16/17 -> 04/06/07
      3'b011:  op = {3'b101, opcode[2:0]};  // 18..1d -> 28..2d
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/dlx_ctrl_decode.sv
// Pure combinational DLX decoder: opcode/funct -> ctrl_bundle_t.
// Ports:
//   id_valid     in   IF/ID holds a real instruction (0 forces the zero bundle)
//   id_opcode    in   instruction[31:26]
//   id_funct     in   instruction[5:0]
//   id_rs2       in   destination for I-type instructions
//   id_rd        in   destination for R-type instructions
//   bundle       out  decoded control word (never X)
//   opcode_known out  opcode is one this decoder understands
// Build option: DLX_CTRL_LINK_EN adds JAL/JALR (link into r31 via the PC+8 path);
// without it those opcodes are reported as unknown.
module dlx_ctrl_decode
  import dlx_ctrl_pkg::*;
(
  input  logic                   id_valid,
  input  logic [5:0]             id_opcode,
  input  logic [5:0]             id_funct,
  input  logic [CTRL_REG_AW-1:0] id_rs2,
  input  logic [CTRL_REG_AW-1:0] id_rd,
  output ctrl_bundle_t           bundle,
  output logic                   opcode_known
);

  ctrl_bundle_t           b;
  logic [CTRL_REG_AW-1:0] dest;

  always_comb begin
    b            = CTRL_ZERO;
    dest         = '0;
    opcode_known = 1'b1;
    case (id_opcode)
      OP_RTYPE, OP_MULT: begin
        b.alu_op     = id_funct;
        b.reg_write  = 1'b1;
        b.mem_to_reg = 1'b1;
        dest         = id_rd;
      end
      OP_ADDI, OP_ADDUI, OP_SUBI, OP_SUBUI, OP_ANDI, OP_ORI, OP_XORI, OP_LHI,
      OP_SLLI, OP_SRLI, OP_SRAI,
      OP_SEQI, OP_SNEI, OP_SLTI, OP_SGTI, OP_SLEI, OP_SGEI: begin
        b.alu_op     = imm_alu_op(id_opcode);
        b.alu_src    = 1'b1;
        b.reg_write  = 1'b1;
        b.mem_to_reg = 1'b1;
        dest         = id_rs2;
      end
      OP_LW: begin
        b.alu_op    = ALU_ADD;
        b.alu_src   = 1'b1;
        b.mem_read  = 1'b1;
        b.reg_write = 1'b1;
        dest        = id_rs2;
      end
      OP_SW: begin
        b.alu_op    = ALU_ADD;
        b.alu_src   = 1'b1;
        b.mem_write = 1'b1;
      end
      OP_J:  b.jump = 1'b1;
      OP_JR: b.jr   = 1'b1;
      OP_BEQZ, OP_BNEZ: begin
        b.alu_op = ALU_SUB;
        b.branch = 1'b1;
      end
`ifdef DLX_CTRL_LINK_EN
      OP_JAL, OP_JALR: begin
        b.jump       = (id_opcode == OP_JAL);
        b.jr         = (id_opcode == OP_JALR);
        b.alu_op     = ALU_LINK;
        b.reg_write  = 1'b1;
        b.mem_to_reg = 1'b1;
        dest         = LINK_REG;
      end
`endif
      default: opcode_known = 1'b0;
    endcase

    // r0 is hardwired: drop the write and clear rd so the hazard compare
    // can never match on a load into r0.
    if (dest == '0) begin
      b.reg_write = 1'b0;
    end
    b.rd = b.reg_write ? dest : '0;

    bundle = id_valid ? b : CTRL_ZERO;
  end

endmodule

// File: rtl/dlx_pipe_ctrl.sv
// Pipelined DLX control unit. Decodes the IF/ID instruction, carries the
// control bundle through ID/EX, EX/MEM and MEM/WB, detects load-use hazards
// (one stall cycle plus a bubble) and sequences multi-cycle flushes after a
// taken branch/jump/JR redirect resolved in EX.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   id_valid/opcode/funct/rs1/rs2/rd   IF/ID instruction fields
//   ex_redirect         taken redirect resolved in EX (1-cycle pulse)
//   pc_stall/ifid_stall hold PC and IF/ID (load-use)
//   if/id/ex_flush      squash IF/ID, ID/EX, EX/MEM contents
//   ex_*                ID/EX control; mem_read/mem_write EX/MEM control
//   wb_*                MEM/WB control; illegal: ID had an unknown opcode last cycle
// Parameters: ALUOP_W/REG_AW must equal the widths in dlx_ctrl_pkg;
// FLUSH_CYC (1..7) is the number of cycles the flush outputs stay high.
// Build option: DLX_CTRL_LINK_EN enables JAL/JALR decode (see dlx_ctrl_decode).
module dlx_pipe_ctrl
  import dlx_ctrl_pkg::*;
#(
  parameter int ALUOP_W   = 6,
  parameter int REG_AW    = 5,
  parameter int FLUSH_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [5:0]         id_opcode,
  input  logic [5:0]         id_funct,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               ex_redirect,
  output logic               pc_stall,
  output logic               ifid_stall,
  output logic               if_flush,
  output logic               id_flush,
  output logic               ex_flush,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic               ex_jr,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [REG_AW-1:0]  wb_rd,
  output logic               illegal
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYC - 1);

  ctrl_bundle_t dec_bundle;
  logic         opcode_known;

  dlx_ctrl_decode u_decode (
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_funct    (id_funct),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .bundle      (dec_bundle),
    .opcode_known(opcode_known)
  );

  flush_state_t           state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  ctrl_bundle_t           idex_q, idex_d;
  logic                   exmem_mem_read_q, exmem_mem_read_d;
  logic                   exmem_mem_write_q, exmem_mem_write_d;
  logic                   exmem_reg_write_q, exmem_reg_write_d;
  logic                   exmem_mem_to_reg_q, exmem_mem_to_reg_d;
  logic [CTRL_REG_AW-1:0] exmem_rd_q, exmem_rd_d;
  logic                   wb_reg_write_q, wb_reg_write_d;
  logic                   wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [CTRL_REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic                   illegal_q, illegal_d;

  logic flush;
  logic load_use;
  logic stall;

  always_comb begin
    // Flush outputs must rise in the redirect cycle itself, so the FSM state
    // only covers the cycles after it. Reset forces every output low.
    flush    = !rst && (ex_redirect || (state_q == ST_FLUSH));
    load_use = idex_q.mem_read && (idex_q.rd != '0) &&
               ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));
    // A redirect squashes the dependent instruction anyway: no stall.
    stall    = !rst && load_use && !flush;

    state_d = state_q;
    cnt_d   = cnt_q;
    if (ex_redirect) begin
      cnt_d   = FLUSH_RELOAD;
      state_d = (FLUSH_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
    end else if (state_q == ST_FLUSH) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        state_d = ST_RUN;
      end
    end

    idex_d             = (flush || stall) ? CTRL_ZERO : dec_bundle;
    exmem_mem_read_d   = flush ? 1'b0 : idex_q.mem_read;
    exmem_mem_write_d  = flush ? 1'b0 : idex_q.mem_write;
    exmem_reg_write_d  = flush ? 1'b0 : idex_q.reg_write;
    exmem_mem_to_reg_d = flush ? 1'b0 : idex_q.mem_to_reg;
    exmem_rd_d         = flush ? '0   : idex_q.rd;
    wb_reg_write_d     = exmem_reg_write_q;
    wb_mem_to_reg_d    = exmem_mem_to_reg_q;
    wb_rd_d            = exmem_rd_q;
    illegal_d          = id_valid && !opcode_known;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= ST_RUN;
      cnt_q              <= 3'd0;
      idex_q             <= CTRL_ZERO;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_rd_q         <= '0;
      wb_reg_write_q     <= 1'b0;
      wb_mem_to_reg_q    <= 1'b0;
      wb_rd_q            <= '0;
      illegal_q          <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      idex_q             <= idex_d;
      exmem_mem_read_q   <= exmem_mem_read_d;
      exmem_mem_write_q  <= exmem_mem_write_d;
      exmem_reg_write_q  <= exmem_reg_write_d;
      exmem_mem_to_reg_q <= exmem_mem_to_reg_d;
      exmem_rd_q         <= exmem_rd_d;
      wb_reg_write_q     <= wb_reg_write_d;
      wb_mem_to_reg_q    <= wb_mem_to_reg_d;
      wb_rd_q            <= wb_rd_d;
      illegal_q          <= illegal_d;
    end
  end

  assign pc_stall      = stall;
  assign ifid_stall    = stall;
  assign if_flush      = flush;
  assign id_flush      = flush;
  assign ex_flush      = flush;
  assign ex_alu_op     = idex_q.alu_op;
  assign ex_alu_src    = idex_q.alu_src;
  assign ex_branch     = idex_q.branch;
  assign ex_jump       = idex_q.jump;
  assign ex_jr         = idex_q.jr;
  assign mem_read      = exmem_mem_read_q;
  assign mem_write     = exmem_mem_write_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_rd         = wb_rd_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// Scoreboard bench for dlx_pipe_ctrl (FLUSH_CYC=3). A driver applies one
// directed vector per cycle and queues the hand-computed outputs expected in
// that cycle; a monitor pops and compares on the falling edge.
module tb_dlx_pipe_ctrl;

`ifdef DLX_CTRL_LINK_EN
  localparam bit LINK = 1'b1;
`else
  localparam bit LINK = 1'b0;
`endif

  logic       clk, rst, id_valid, ex_redirect;
  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       pc_stall, ifid_stall, if_flush, id_flush, ex_flush;
  logic [5:0] ex_alu_op;
  logic       ex_alu_src, ex_branch, ex_jump, ex_jr, mem_read, mem_write;
  logic       wb_reg_write, wb_mem_to_reg, illegal;
  logic [4:0] wb_rd;

  dlx_pipe_ctrl #(.ALUOP_W(6), .REG_AW(5), .FLUSH_CYC(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_redirect(ex_redirect), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_jr(ex_jr), .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
    .illegal(illegal)
  );

  typedef struct packed {
    logic       rst, valid, redir;
    logic [5:0] op, fn;
    logic [4:0] rs1, rs2, rd;
  } stim_t;

  typedef struct packed {
    logic [7:0] idx;
    logic       stall, flush;
    logic [5:0] exop;
    logic       exsrc, exbr, exj, exjr, mr, mw, rw, m2r;
    logic [4:0] wrd;
    logic       ill;
  } exp_t;

  stim_t stim_tab[$];
  exp_t  exp_tab[$];
  exp_t  sb_q[$];
  int    n_chk = 0;
  int    n_fail = 0;

  function automatic stim_t S(int valid, int op, int fn, int rs1, int rs2, int rd,
                              int redir = 0, int r = 0);
    stim_t s;
    s.rst = 1'(r); s.valid = 1'(valid); s.redir = 1'(redir);
    s.op = 6'(op); s.fn = 6'(fn); s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
    return s;
  endfunction

  function automatic exp_t E(int stall, int flush, int exop, int exsrc, int exbr,
                             int exj, int exjr, int mr, int mw, int rw, int m2r,
                             int wrd, int ill);
    exp_t e;
    e.idx = '0; e.stall = 1'(stall); e.flush = 1'(flush); e.exop = 6'(exop);
    e.exsrc = 1'(exsrc); e.exbr = 1'(exbr); e.exj = 1'(exj); e.exjr = 1'(exjr);
    e.mr = 1'(mr); e.mw = 1'(mw); e.rw = 1'(rw); e.m2r = 1'(m2r);
    e.wrd = 5'(wrd); e.ill = 1'(ill);
    return e;
  endfunction

  task automatic add(input stim_t s, input exp_t e);
    stim_tab.push_back(s);
    exp_tab.push_back(e);
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Monitor: compare every queued expectation against the outputs mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("stall", int'(e.idx), {30'd0, pc_stall, ifid_stall}, {30'd0, e.stall, e.stall});
        chk("flush", int'(e.idx), {29'd0, if_flush, id_flush, ex_flush},
            {29'd0, e.flush, e.flush, e.flush});
        chk("ex_ctrl", int'(e.idx), {22'd0, ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_jr},
            {22'd0, e.exop, e.exsrc, e.exbr, e.exj, e.exjr});
        chk("mem_ctrl", int'(e.idx), {30'd0, mem_read, mem_write}, {30'd0, e.mr, e.mw});
        chk("wb_ctrl", int'(e.idx), {25'd0, wb_reg_write, wb_mem_to_reg, wb_rd},
            {25'd0, e.rw, e.m2r, e.wrd});
        chk("illegal", int'(e.idx), {31'd0, illegal}, {31'd0, e.ill});
      end
    end
  end

  // Driver
  initial begin
    stim_t s;
    exp_t  e;
    rst = 1'b1; id_valid = 1'b0; ex_redirect = 1'b0;
    id_opcode = '0; id_funct = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;

    //         valid op    fn    rs1 rs2 rd redir rst      stall fl exop src br j jr mr mw rw m2r wrd ill
    add(S(0, 0,    0,    0, 0, 0, 0, 1), E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 0 reset
    add(S(1, 'h08, 0,    1, 2, 0),       E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 1 ADDI r2,r1,5
    add(S(0, 0,    0,    0, 0, 0),       E(0,0,'h20,1,0,0,0, 0,0, 0,0,0, 0));  // 2
    add(S(0, 0,    0,    0, 0, 0),       E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 3
    add(S(0, 0,    0,    0, 0, 0),       E(0,0,0,   0,0,0,0, 0,0, 1,1,2, 0));  // 4 ADDI in WB
    add(S(1, 'h23, 0,    1, 3, 0),       E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 5 LW r3
    add(S(1, 'h00, 'h20, 3, 1, 4),       E(1,0,'h20,1,0,0,0, 0,0, 0,0,0, 0));  // 6 ADD r4,r3,r1 stall
    add(S(1, 'h00, 'h20, 3, 1, 4),       E(0,0,0,   0,0,0,0, 1,0, 0,0,0, 0));  // 7 ADD held, bubble
    add(S(0, 0,    0,    0, 0, 0),       E(0,0,'h20,0,0,0,0, 0,0, 1,0,3, 0));  // 8
    add(S(1, 'h23, 0,    1, 0, 0),       E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 9 LW r0
    add(S(1, 'h00, 'h20, 0, 0, 4),       E(0,0,'h20,1,0,0,0, 0,0, 1,1,4, 0));  // 10 ADD r4,r0,r0 no stall
    add(S(0, 0,    0,    0, 0, 0),       E(0,0,'h20,0,0,0,0, 1,0, 0,0,0, 0));  // 11
    add(S(1, 'h3f, 0,    0, 0, 0),       E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 12 unknown op
    add(S(0, 0,    0,    0, 0, 0),       E(0,0,0,   0,0,0,0, 0,0, 1,1,4, 1));  // 13 illegal
    add(S(1, 'h03, 0,    0, 0, 0),       E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 14 op 03
    add(S(0, 0,    0,    0, 0, 0),
        E(0,0,LINK ? 'h11 : 0,0,0,int'(LINK),0, 0,0, 0,0,0, int'(!LINK)));     // 15
    add(S(1, 'h04, 0,    5, 0, 0),       E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 16 BEQZ
    add(S(0, 0,    0,    0, 0, 0, 1),
        E(0,1,'h22,0,1,0,0, 0,0, int'(LINK),int'(LINK),LINK ? 31 : 0, 0));     // 17 redirect
    add(S(1, 'h2b, 0,    1, 2, 0),       E(0,1,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 18 SW squashed
    add(S(0, 0,    0,    0, 0, 0),       E(0,1,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 19
    add(S(1, 'h02, 0,    0, 0, 0),       E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 20 J
    add(S(0, 0,    0,    0, 0, 0, 1),    E(0,1,0,   0,0,1,0, 0,0, 0,0,0, 0));  // 21 redirect
    add(S(0, 0,    0,    0, 0, 0, 1),    E(0,1,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 22 redirect mid-flush
    add(S(0, 0,    0,    0, 0, 0),       E(0,1,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 23
    add(S(0, 0,    0,    0, 0, 0),       E(0,1,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 24
    add(S(0, 0,    0,    0, 0, 0),       E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 25
    add(S(1, 'h23, 0,    1, 3, 0),       E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 26 LW r3
    add(S(1, 'h00, 'h20, 3, 1, 4, 1),    E(0,1,'h20,1,0,0,0, 0,0, 0,0,0, 0));  // 27 load-use + redirect
    add(S(0, 0,    0,    0, 0, 0),       E(0,1,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 28 LW squashed
    add(S(0, 0,    0,    0, 0, 0),       E(0,1,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 29
    add(S(1, 'h12, 0,    7, 0, 0),       E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 30 JR
    add(S(1, 'h2b, 0,    1, 2, 0),       E(0,0,0,   0,0,0,1, 0,0, 0,0,0, 0));  // 31 SW
    add(S(1, 'h01, 'h0e, 1, 2, 9),       E(0,0,'h20,1,0,0,0, 0,0, 0,0,0, 0));  // 32 MULT r9
    add(S(1, 'h14, 0,    1, 6, 0),       E(0,0,'h0e,0,0,0,0, 0,1, 0,0,0, 0));  // 33 SLLI r6
    add(S(1, 'h23, 0,    1, 3, 0),       E(0,0,'h04,1,0,0,0, 0,0, 0,0,0, 0));  // 34 LW r3
    add(S(1, 'h00, 'h20, 3, 1, 4),       E(1,0,'h20,1,0,0,0, 0,0, 1,1,9, 0));  // 35 stall
    add(S(1, 'h00, 'h20, 3, 1, 4, 0, 1), E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 36 reset mid-stall
    add(S(0, 0,    0,    0, 0, 0, 1),    E(0,1,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 37 redirect
    add(S(0, 0,    0,    0, 0, 0, 1, 1), E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 38 reset mid-flush
    add(S(0, 0,    0,    0, 0, 0),       E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 39 RUN
    add(S(1, 'h08, 0,    1, 2, 0),       E(0,0,0,   0,0,0,0, 0,0, 0,0,0, 0));  // 40 ADDI
    add(S(0, 0,    0,    0, 0, 0),       E(0,0,'h20,1,0,0,0, 0,0, 0,0,0, 0));  // 41

    for (int i = 0; i < stim_tab.size(); i++) begin
      @(posedge clk);
      #1;
      s           = stim_tab[i];
      rst         = s.rst;
      id_valid    = s.valid;
      ex_redirect = s.redir;
      id_opcode   = s.op;
      id_funct    = s.fn;
      id_rs1      = s.rs1;
      id_rs2      = s.rs2;
      id_rd       = s.rd;
      e           = exp_tab[i];
      e.idx       = 8'(i);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; id_valid = 1'b0; ex_redirect = 1'b0;
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", stim_tab.size(), 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
